gcd_kop: RTL and testbench

Parametrised successor to the two-operand GCD unit. It computes the greatest common divisor of K unsigned W-bit operands, which a requester delivers one at a time over a shared operand bus using a 4-phase req/ack handshake. The block folds each new operand into a running result (gcd(a,b,c) = gcd(gcd(a,b),c)), defines zero-operand behaviour, and offers a compile-time binary-GCD datapath. It sits between a handshaking requester (bench or control FSM) and any consumer of C.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_step_core.sv | 104 ++++++++++
 rtl/gcd_kop.sv | 105 ++++++++++
 tb/tb_gcd_kop.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the K-operand GCD unit (gcd_kop / gcd_step_core).
package gcd_pkg;

  localparam int unsigned GCD_W_DEFAULT = 16;
  localparam int unsigned GCD_K_DEFAULT = 2;

  typedef enum logic [2:0] {
    WAIT_REQ = 3'd0,
    ACK_OP   = 3'd1,
    COMPUTE  = 3'd2,
    ACK_RES  = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // True when the pair needs no further stepping: a zero operand or equal operands.
  function automatic logic gcd_term(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'd0) || (b == 32'd0) || (a == b);
  endfunction

endpackage

// File: rtl/gcd_step_core.sv
// A/B datapath doing one GCD step per cycle; subtract Euclid by default,
// binary (Stein) GCD with a shift count when GCD_STEIN_EN is defined.
module gcd_step_core
  import gcd_pkg::*;
#(
  parameter int unsigned W = GCD_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         load_a_i,
  input  logic         load_b_i,
  input  logic [W-1:0] ab_i,
  output logic         done_c,
  output logic [W-1:0] result_c
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] base_c;

  assign done_c = gcd_term(32'(a_q), 32'(b_q));
  assign base_c = (a_q == '0) ? b_q : a_q;

`ifdef GCD_STEIN_EN
  localparam int unsigned KW = $clog2(W);

  logic [KW-1:0] k_q, k_d;

  // Common factors of two removed while stepping are restored on the way out.
  assign result_c = base_c << k_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    if (load_a_i) begin
      a_d = ab_i;
    end else if (load_b_i) begin
      b_d = ab_i;
      k_d = '0;
    end else if (start_i) begin
      if (done_c) begin
        a_d = result_c;
      end else if (!a_q[0] && !b_q[0]) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end else if (!a_q[0]) begin
        a_d = a_q >> 1;
      end else if (!b_q[0]) begin
        b_d = b_q >> 1;
      end else if (a_q > b_q) begin
        a_d = (a_q - b_q) >> 1;
      end else begin
        b_d = (b_q - a_q) >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
    end
  end
`else
  assign result_c = base_c;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_a_i) begin
      a_d = ab_i;
    end else if (load_b_i) begin
      b_d = ab_i;
    end else if (start_i) begin
      if (done_c) begin
        a_d = result_c;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else begin
        b_d = b_q - a_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
`endif

endmodule

// File: rtl/gcd_kop.sv
// K-operand GCD over a 4-phase req/ack operand bus; folds each operand into a
// running result C. GCD_STEIN_EN selects the binary-GCD step datapath.
module gcd_kop
  import gcd_pkg::*;
#(
  parameter int unsigned W = GCD_W_DEFAULT,
  parameter int unsigned K = GCD_K_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [W-1:0] AB,
  output logic         ack,
  output logic [W-1:0] C
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [W-1:0]  c_q, c_d;
  logic          start_c, load_a_c, load_b_c, done_c, last_c;
  logic [W-1:0]  result_c;

  assign last_c = (cnt_q == CW'(K - 1));
  assign ack    = ack_q;
  assign C      = c_q;

  gcd_step_core #(.W(W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_c),
    .load_a_i (load_a_c),
    .load_b_i (load_b_c),
    .ab_i     (AB),
    .done_c   (done_c),
    .result_c (result_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= WAIT_REQ;
    else        state_q <= state_d;
  end

  // Next-state logic; COMPUTE ignores req so an early release still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_REQ: if (req) state_d = (cnt_q == '0) ? ACK_OP : COMPUTE;
      ACK_OP:   state_d = WAIT_REL;
      COMPUTE:  if (done_c) state_d = WAIT_REL;
      WAIT_REL: if (!req) state_d = WAIT_REQ;
      default:  state_d = WAIT_REQ;
    endcase
  end

  // Output / datapath control
  always_comb begin
    ack_d    = ack_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    start_c  = 1'b0;
    load_a_c = 1'b0;
    load_b_c = 1'b0;
    case (state_q)
      WAIT_REQ: begin
        if (req) begin
          load_a_c = (cnt_q == '0);
          load_b_c = (cnt_q != '0);
        end
      end
      ACK_OP: ack_d = 1'b1;
      COMPUTE: begin
        start_c = 1'b1;
        if (done_c) begin
          c_d   = result_c;
          ack_d = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!req) begin
          ack_d = 1'b0;
          cnt_d = last_c ? '0 : cnt_q + CW'(1);
        end
      end
      default: ack_d = 1'b0;
    endcase
  end

  // Registered outputs and operand index
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_q <= 1'b0;
      c_q   <= '0;
      cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gcd_kop.sv
// Scoreboard bench for gcd_kop: K=2 and K=3 instances behind a select mux;
// latency limits depend on GCD_STEIN_EN.
module tb_gcd_kop;

  localparam int BUDGET = 70000;

  typedef struct {
    string       name;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [15:0] AB;
  logic        sel;
  logic        ack2, ack3, ack_m;
  logic [15:0] C2, C3, C_m;

  exp_t        sb_q[$];
  logic [15:0] c_model[2];
  int          n_pass = 0;
  int          n_total = 0;

  logic [15:0] va[9] = '{16'd91, 16'd32768, 16'd49, 16'd29232, 16'd25, 16'd0, 16'd45, 16'd0, 16'd4};
  logic [15:0] vb[9] = '{16'd63, 16'd272, 16'd98, 16'd488, 16'd5, 16'd45, 16'd0, 16'd0, 16'd4};
  logic [15:0] ve[9] = '{16'd7, 16'd16, 16'd49, 16'd8, 16'd5, 16'd45, 16'd45, 16'd0, 16'd4};
  bit          vl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  gcd_kop #(.W(16), .K(2)) dut2 (
    .clk(clk), .reset(reset), .req(req & ~sel), .AB(AB), .ack(ack2), .C(C2)
  );

  gcd_kop #(.W(16), .K(3)) dut3 (
    .clk(clk), .reset(reset), .req(req & sel), .AB(AB), .ack(ack3), .C(C3)
  );

  assign ack_m = sel ? ack3 : ack2;
  assign C_m   = sel ? C3 : C2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Present one operand, wait for ack, release and confirm ack drops.
  task automatic send_op(input logic [15:0] v, input logic [15:0] exp_c, input string name,
                         output int lat);
    sb_q.push_back('{name, exp_c});
    c_model[sel] = exp_c;
    AB  = v;
    req = 1'b1;
    lat = 0;
    while (!ack_m && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (!ack_m) begin
      n_total++;
      $display("FAIL %s_timeout: ack=0 after %0d cycles, required 1", name, lat);
    end
    req = 1'b0;
    @(negedge clk);
    check({name, "_rel"}, 32'(ack_m), 32'd0);
  endtask

  task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_c,
                      input string name, output int lat);
    int l0;
    send_op(a, c_model[sel], {name, "_op0"}, l0);
    check({name, "_op0_lat"}, 32'(l0), 32'd2);
    send_op(b, exp_c, name, lat);
  endtask

  // Monitor: every rising ack presents a result to compare against the queue.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_m && !prev) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ack: C=%0d with no result expected", C_m);
        end else begin
          e = sb_q.pop_front();
          check(e.name, 32'(C_m), 32'(e.c));
        end
      end
      prev = ack_m;
    end
  end

  initial begin
    int lat;
    int n;
    sel   = 1'b0;
    req   = 1'b0;
    AB    = '0;
    reset = 1'b0;
    c_model[0] = '0;
    c_model[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack2", 32'(ack2), 32'd0);
    check("rst_c2", 32'(C2), 32'd0);
    check("rst_ack3", 32'(ack3), 32'd0);
    check("rst_c3", 32'(C3), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run2(va[i], vb[i], ve[i], $sformatf("pair%0d", i), lat);
      if (vl[i]) check($sformatf("pair%0d_lat", i), 32'(lat), 32'd2);
    end

    // K=3 fold with intermediate partial result
    sel = 1'b1;
    @(negedge clk);
    send_op(16'd48, c_model[1], "k3_op0", lat);
    check("k3_op0_lat", 32'(lat), 32'd2);
    send_op(16'd180, 16'd12, "k3_op1", lat);
    send_op(16'd30, 16'd6, "k3_final", lat);
    sel = 1'b0;
    @(negedge clk);

    // req released before ack: single-cycle ack pulse, index back to 0
    send_op(16'd91, c_model[0], "viol_op0", lat);
    sb_q.push_back('{"viol", 16'd7});
    c_model[0] = 16'd7;
    AB  = 16'd63;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!ack_m && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("viol_ack", 32'(ack_m), 32'd1);
    @(negedge clk);
    check("viol_pulse", 32'(ack_m), 32'd0);
    run2(16'd12, 16'd18, 16'd6, "post_viol", lat);

    // Reset in the middle of a long computation
    send_op(16'd65535, c_model[0], "abort_op0", lat);
    AB  = 16'd1;
    req = 1'b1;
    repeat (101) @(negedge clk);
    check("abort_busy", 32'(ack_m), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ack", 32'(ack2), 32'd0);
    check("abort_c2", 32'(C2), 32'd0);
    check("abort_c3", 32'(C3), 32'd0);
    c_model[0] = '0;
    c_model[1] = '0;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run2(16'd12, 16'd18, 16'd6, "post_rst", lat);

    // Worst-case operand pair: latency is 2 + step count
    run2(16'd65535, 16'd1, 16'd1, "long", lat);
`ifdef GCD_STEIN_EN
    check("long_lat_le35", 32'(lat <= 35), 32'd1);
`else
    check("long_lat", 32'(lat), 32'd65536);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
